// File: rtl/vga_demo_pkg.sv
// Shared constants and types for the VGA demo pixel sources.
// Holds the visible-area timing constants (also used by the timing block),
// a few named colours, the box direction enums and the box colour stepper.
package vga_demo_pkg;

  // Visible area of the 640x480 mode
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  // Colours as {r,g,b}
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_RED   = 3'b100;

  // Horizontal and vertical travel directions of the box
  typedef enum logic {RIGHT = 1'b0, LEFT = 1'b1} dir_x_t;
  typedef enum logic {DOWN  = 1'b0, UP   = 1'b1} dir_y_t;

  // Box colour sequence 1..7, skipping black so the box never vanishes
  function automatic logic [2:0] next_box_col(input logic [2:0] col);
    return (col == 3'd7) ? 3'd1 : col + 3'd1;
  endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Frame-start pulse generator: one clk_25M-wide pulse, one cycle after the
// timing block first reports the first blanking line at column 0.
// Edge-detected so a condition lasting several cycles still gives one pulse.
module vga_frame_tick
  import vga_demo_pkg::*;
#(
  parameter int unsigned V_LINE = V_ACTIVE
) (
  input  logic       clk_25M,
  input  logic       rst,
  input  logic [9:0] hcnt,
  input  logic [9:0] vcnt,
  output logic       frame_tick
);

  logic seen_d, seen_q;
  logic tick_d, tick_q;

  // Detect the frame-start position and its rising edge
  always_comb begin
    seen_d = (vcnt == 10'(V_LINE)) && (hcnt == 10'd0);
    tick_d = seen_d && !seen_q;
  end

  // Register the condition history and the pulse
  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      seen_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      seen_q <= seen_d;
      tick_q <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/vga_bounce_box.sv
// Bouncing-box pixel source feeding the VGA timing block.
// Draws a box over a flat background; once every FRAME_DIV frames the box
// moves STEP pixels diagonally, reflects off the visible-area edges and
// steps its colour on every bounce (a corner hit counts once).
// Optional build macro VGA_BOX_BORDER_EN: draws the box perimeter in white.
module vga_bounce_box
  import vga_demo_pkg::*;
#(
  parameter int unsigned BOX_W     = 32,
  parameter int unsigned BOX_H     = 32,
  parameter int unsigned STEP      = 2,
  parameter int unsigned FRAME_DIV = 1,
  parameter logic [2:0]  BG_COLOR  = 3'b001
) (
  input  logic       clk_25M,
  input  logic       rst,
  input  logic       en,
  input  logic [9:0] hcnt,
  input  logic [9:0] vcnt,
  output logic [2:0] color,
  output logic       frame_tick,
  output logic [7:0] bounce_cnt
);

  // 11-bit working width so x+BOX_W and y+BOX_H never overflow
  localparam logic [10:0] XMAX     = 11'(H_ACTIVE - BOX_W);
  localparam logic [10:0] YMAX     = 11'(V_ACTIVE - BOX_H);
  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [10:0] BOX_W_W  = 11'(BOX_W);
  localparam logic [10:0] BOX_H_W  = 11'(BOX_H);
  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [3:0]  DIV_LAST = 4'(FRAME_DIV - 1);

  logic [10:0] x_d, x_q, y_d, y_q;
  dir_x_t      dir_x_d, dir_x_q;
  dir_y_t      dir_y_d, dir_y_q;
  logic [2:0]  box_col_d, box_col_q;
  logic [3:0]  div_d, div_q;
  logic [7:0]  bounce_cnt_d, bounce_cnt_q;
  logic [2:0]  color_d, color_q;
  logic        bounce_x, bounce_y;
  logic [10:0] h_w, v_w;
  logic        in_active, in_box, on_edge;

  vga_frame_tick #(
    .V_LINE(V_ACTIVE)
  ) u_frame_tick (
    .clk_25M   (clk_25M),
    .rst       (rst),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .frame_tick(frame_tick)
  );

  // Motion: divider, per-axis reflection and bounce bookkeeping on move ticks
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    box_col_d    = box_col_q;
    div_d        = div_q;
    bounce_cnt_d = bounce_cnt_q;
    bounce_x     = 1'b0;
    bounce_y     = 1'b0;
    if (frame_tick && en) begin
      if (div_q == DIV_LAST) begin
        div_d = 4'd0;
        // X axis
        if (dir_x_q == RIGHT) begin
          if (x_q >= XMAX - STEP_W) begin
            x_d      = XMAX;
            dir_x_d  = LEFT;
            bounce_x = 1'b1;
          end else begin
            x_d = x_q + STEP_W;
          end
        end else begin
          if (x_q <= STEP_W) begin
            x_d      = 11'd0;
            dir_x_d  = RIGHT;
            bounce_x = 1'b1;
          end else begin
            x_d = x_q - STEP_W;
          end
        end
        // Y axis
        if (dir_y_q == DOWN) begin
          if (y_q >= YMAX - STEP_W) begin
            y_d      = YMAX;
            dir_y_d  = UP;
            bounce_y = 1'b1;
          end else begin
            y_d = y_q + STEP_W;
          end
        end else begin
          if (y_q <= STEP_W) begin
            y_d      = 11'd0;
            dir_y_d  = DOWN;
            bounce_y = 1'b1;
          end else begin
            y_d = y_q - STEP_W;
          end
        end
        // A corner hit is a single bounce event
        if (bounce_x || bounce_y) begin
          bounce_cnt_d = bounce_cnt_q + 8'd1;
          box_col_d    = next_box_col(box_col_q);
        end
      end else begin
        div_d = div_q + 4'd1;
      end
    end
  end

  // Pixel colour for the coordinate currently presented by the timing block
  always_comb begin
    h_w       = {1'b0, hcnt};
    v_w       = {1'b0, vcnt};
    in_active = (h_w < H_ACT_W) && (v_w < V_ACT_W);
    in_box    = (h_w >= x_q) && (h_w < x_q + BOX_W_W) &&
                (v_w >= y_q) && (v_w < y_q + BOX_H_W);
`ifdef VGA_BOX_BORDER_EN
    on_edge   = (h_w == x_q) || (h_w == x_q + BOX_W_W - 11'd1) ||
                (v_w == y_q) || (v_w == y_q + BOX_H_W - 11'd1);
`else
    on_edge   = 1'b0;
`endif
    if (!in_active) begin
      color_d = COL_BLACK;
    end else if (in_box) begin
      color_d = on_edge ? COL_WHITE : box_col_q;
    end else begin
      color_d = BG_COLOR;
    end
  end

  // State and output registers
  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      x_q          <= 11'd0;
      y_q          <= 11'd0;
      dir_x_q      <= RIGHT;
      dir_y_q      <= DOWN;
      box_col_q    <= COL_RED;
      div_q        <= 4'd0;
      bounce_cnt_q <= 8'd0;
      color_q      <= COL_BLACK;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      box_col_q    <= box_col_d;
      div_q        <= div_d;
      bounce_cnt_q <= bounce_cnt_d;
      color_q      <= color_d;
    end
  end

  assign color      = color_q;
  assign bounce_cnt = bounce_cnt_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Bench for vga_bounce_box: a driver presents pixel coordinates and queues the
// expected response; a monitor pops and compares one cycle later.
module tb_vga_bounce_box;

  localparam logic [2:0] BG = 3'b001;

  logic       clk_25M = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [2:0] color;
  logic       frame_tick;
  logic [7:0] bounce_cnt;

  typedef struct packed {
    logic       cc;
    logic [2:0] col;
    logic       ct;
    logic       tk;
    logic       cb;
    logic [7:0] bc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  bit    probe_flag = 1'b0;
  bit    mon_f;
  exp_t  mon_e;
  string mon_n;
  int    checks = 0;
  int    errors = 0;

  vga_bounce_box dut (
    .clk_25M   (clk_25M),
    .rst       (rst),
    .en        (en),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .color     (color),
    .frame_tick(frame_tick),
    .bounce_cnt(bounce_cnt)
  );

  always #5 clk_25M = ~clk_25M;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic cc, input logic [2:0] col, input logic ct,
                              input logic tk, input logic cb, input logic [7:0] bc);
    exp_t e;
    e.cc = cc; e.col = col; e.ct = ct; e.tk = tk; e.cb = cb; e.bc = bc;
    return e;
  endfunction

  // Expected colour outside the box
  function automatic logic [2:0] outside(input int h, input int v);
    return (h >= 640 || v >= 480) ? 3'b000 : BG;
  endfunction

  // Expected colour on a box perimeter pixel
  function automatic logic [2:0] edge_col(input logic [2:0] col);
`ifdef VGA_BOX_BORDER_EN
    return 3'b111;
`else
    return col;
`endif
  endfunction

  task automatic drive(input int h, input int v, input exp_t e, input string nm);
    @(negedge clk_25M);
    hcnt = h[9:0];
    vcnt = v[9:0];
    exp_q.push_back(e);
    name_q.push_back(nm);
    probe_flag = 1'b1;
  endtask

  // Short synthetic frame: start-of-blanking for two cycles, then elsewhere
  task automatic frame(input logic c, input string nm);
    drive(0, 480, mk(0, 0, c, 1, 0, 0), {nm, "_tick"});
    drive(0, 480, mk(0, 0, c, 0, 0, 0), {nm, "_hold"});
    drive(5, 100, mk(0, 0, c, 0, 0, 0), {nm, "_after"});
  endtask

  // Probe pixels around the expected box at (x,y) with colour col
  task automatic check_box(input int x, input int y, input logic [2:0] col,
                           input logic [7:0] bc, input string nm);
    drive(x + 1, y + 1, mk(1, col, 0, 0, 1, bc), {nm, "_in_tl"});
    drive(x + 30, y + 30, mk(1, col, 0, 0, 0, 0), {nm, "_in_br"});
    drive(x + 32, y + 1, mk(1, outside(x + 32, y + 1), 0, 0, 0, 0), {nm, "_right"});
    drive(x + 1, y + 32, mk(1, outside(x + 1, y + 32), 0, 0, 0, 0), {nm, "_below"});
    if (x > 0) drive(x - 1, y + 1, mk(1, BG, 0, 0, 0, 0), {nm, "_left"});
    if (y > 0) drive(x + 1, y - 1, mk(1, BG, 0, 0, 0, 0), {nm, "_above"});
  endtask

  // Monitor: outputs for a coordinate presented before a rising edge are
  // valid just after that edge
  initial begin
    forever begin
      @(posedge clk_25M);
      mon_f = probe_flag;
      probe_flag = 1'b0;
      #1;
      if (mon_f) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_n = name_q.pop_front();
          if (mon_e.cc) chk({mon_n, "_color"}, int'(color), int'(mon_e.col));
          if (mon_e.ct) chk({mon_n, "_frame_tick"}, int'(frame_tick), int'(mon_e.tk));
          if (mon_e.cb) chk({mon_n, "_bounce_cnt"}, int'(bounce_cnt), int'(mon_e.bc));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    hcnt = 10'd0;
    vcnt = 10'd0;
    repeat (3) @(posedge clk_25M);
    @(negedge clk_25M);
    chk("reset_color", int'(color), 0);
    chk("reset_frame_tick", int'(frame_tick), 0);
    chk("reset_bounce_cnt", int'(bounce_cnt), 0);
    rst = 1'b0;

    // First move: box at (2,2), red
    frame(1, "f1");
    drive(2, 2, mk(1, edge_col(3'b100), 0, 0, 1, 8'd0), "f1_corner_px");
    drive(1, 2, mk(1, BG, 0, 0, 0, 0), "f1_left_px");
    check_box(2, 2, 3'b100, 8'd0, "f1");

    // Up to move 303: y bounced at move 224
    for (int i = 0; i < 302; i++) frame(0, "run");
    check_box(606, 290, 3'b101, 8'd1, "m303");
    frame(1, "f304");
    check_box(608, 288, 3'b110, 8'd2, "m304");
    frame(1, "f305");
    check_box(606, 286, 3'b110, 8'd2, "m305");

    // Up to move 4255, then a corner hit at (0,448) counting once
    for (int i = 0; i < 3950; i++) frame(0, "run");
    check_box(2, 446, 3'b111, 8'd31, "m4255");
    frame(1, "f4256");
    check_box(0, 448, 3'b001, 8'd32, "corner");
    frame(1, "f4257");
    check_box(2, 446, 3'b001, 8'd32, "m4257");

    // Frozen: ticks continue, box holds
    en = 1'b0;
    for (int i = 0; i < 10; i++) frame(1, "frozen");
    check_box(2, 446, 3'b001, 8'd32, "frozen");
    en = 1'b1;
    frame(1, "resume");
    check_box(4, 444, 3'b001, 8'd32, "resume");

    // Blanking and out-of-range coordinates
    drive(700, 100, mk(1, 3'b000, 0, 0, 0, 0), "blank_h700");
    drive(100, 500, mk(1, 3'b000, 0, 0, 0, 0), "blank_v500");
    drive(640, 100, mk(1, 3'b000, 0, 0, 0, 0), "blank_h640");
    drive(639, 100, mk(1, BG, 0, 0, 0, 0), "bg_h639");
    drive(1000, 1000, mk(1, 3'b000, 0, 0, 0, 0), "blank_far");
    // Perimeter vs interior
    drive(4, 449, mk(1, edge_col(3'b001), 0, 0, 0, 0), "edge_px");
    drive(9, 449, mk(1, 3'b001, 0, 0, 0, 0), "interior_px");

    // Asynchronous reset mid-cycle
    @(posedge clk_25M);
    #2;
    chk("pre_rst_color", int'(color), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_color", int'(color), 0);
    chk("async_rst_bounce_cnt", int'(bounce_cnt), 0);
    repeat (3) @(posedge clk_25M);
    @(negedge clk_25M);
    rst  = 1'b0;
    hcnt = 10'd0;
    vcnt = 10'd0;
    frame(1, "post_rst");
    check_box(2, 2, 3'b100, 8'd0, "post_rst");

    repeat (3) @(posedge clk_25M);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
